// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the M-stage LSU: funct3 sizes, FSM states, byte-enable patterns
// and the legality and store-formatting rules used by the top level.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_fmt_t;

    // Unsigned widths exist only for loads; everything else must be naturally aligned.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = !is_store;
            F3_HU:   ok = !is_store && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic st_fmt_t store_fmt(input logic [1:0] size, input logic [1:0] off,
                                          input logic [31:0] wd);
        st_fmt_t f;
        f.wdata = wd;
        f.be    = BE_WORD;
        case (size)
            2'b00: begin
                f.wdata = {4{wd[7:0]}};
                f.be    = BE_BYTE << off;
            end
            2'b01: begin
                f.wdata = {2{wd[15:0]}};
                f.be    = off[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Word-aligned data-memory request/acknowledge bus; rdata is valid in the ack cycle.
// The LSU holds every request field stable until ack (no other backpressure).
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
// Purely combinational, zero latency, no flow control.
module lsu_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*off +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: IDLE->BUSY->DONE per access, minimum two stall cycles.
// Pipeline is frozen via stall_m while waiting for dmem_ack; a timeout ends the wait.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_m,
    input  logic        memwrite_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] aluresult_m,
    input  logic [31:0] writedata_m,
    output logic [31:0] rd,
    output logic        stall_m,
    output logic        access_fault_m,
    output logic        bus_err_m,
    mem_stage_lsu_if.master dmem
);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    lsu_state_t  state;
    logic [7:0]  wait_cnt;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] load_data;
    logic        access;
    logic        legal;
    st_fmt_t     fmt;

    // A simultaneous read+write is treated as a store, so legality uses the store rules.
    assign access         = memread_m | memwrite_m;
    assign legal          = access_legal(memwrite_m, funct3_m, aluresult_m[1:0]);
    assign fmt            = store_fmt(funct3_m[1:0], aluresult_m[1:0], writedata_m);
    assign access_fault_m = access & ~legal;
    assign stall_m        = ((state == ST_IDLE) & access & legal) | (state == ST_BUSY);

    lsu_load_align u_align (
        .rdata  (dmem.dmem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            wait_cnt        <= 8'd0;
            off_q           <= 2'b00;
            f3_q            <= 3'b000;
            rd              <= 32'd0;
            bus_err_m       <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'd0;
            dmem.dmem_wdata <= 32'd0;
            dmem.dmem_be    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus_err_m <= 1'b0;
                    if (access && legal) begin
                        state           <= ST_BUSY;
                        wait_cnt        <= 8'd0;
                        off_q           <= aluresult_m[1:0];
                        f3_q            <= funct3_m;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= memwrite_m;
                        dmem.dmem_addr  <= {aluresult_m[31:2], 2'b00};
                        dmem.dmem_wdata <= memwrite_m ? fmt.wdata : 32'd0;
                        dmem.dmem_be    <= fmt.be;
                    end
                end
                ST_BUSY: begin
                    if (dmem.dmem_ack) begin
                        rd            <= dmem.dmem_we ? 32'd0 : load_data;
                        state         <= ST_DONE;
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rd            <= 32'd0;
                        bus_err_m     <= 1'b1;
                        state         <= ST_DONE;
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    bus_err_m <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu against a transaction-level expectation model.
module tb_mem_stage_lsu;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread_m, memwrite_m;
    logic [2:0]  funct3_m;
    logic [31:0] aluresult_m, writedata_m;
    logic [31:0] rd;
    logic        stall_m, access_fault_m, bus_err_m;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu #(.MAX_WAIT(MAXW)) dut (
        .clk            (clk),
        .reset          (reset),
        .memread_m      (memread_m),
        .memwrite_m     (memwrite_m),
        .funct3_m       (funct3_m),
        .aluresult_m    (aluresult_m),
        .writedata_m    (writedata_m),
        .rd             (rd),
        .stall_m        (stall_m),
        .access_fault_m (access_fault_m),
        .bus_err_m      (bus_err_m),
        .dmem           (dmem)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    logic        exp_stall, exp_fault, exp_req, exp_we, exp_err;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_be;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference rules, expressed as plain arithmetic on the architectural access.
    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        bit f3_ok;
        f3_ok = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return f3_ok && ((a % acc_bytes(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] w, output logic [3:0] be);
        int n;
        n = acc_bytes(f3);
        if (n == 1) begin
            w  = (wd & 32'hFF) * 32'h01010101;
            be = 4'(1 << (a % 4));
        end else if (n == 2) begin
            w  = (wd & 32'hFFFF) * 32'h00010001;
            be = 4'(3 << (a % 4));
        end else begin
            w  = wd;
            be = 4'hF;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("stall_m", 32'(stall_m), 32'(exp_stall));
            cmp("access_fault_m", 32'(access_fault_m), 32'(exp_fault));
            cmp("dmem_req", 32'(dmem.dmem_req), 32'(exp_req));
            cmp("bus_err_m", 32'(bus_err_m), 32'(exp_err));
            cmp("rd", rd, exp_rd);
            if (exp_req) begin
                cmp("dmem_we", 32'(dmem.dmem_we), 32'(exp_we));
                cmp("dmem_addr", dmem.dmem_addr, exp_addr);
                if (exp_we) begin
                    cmp("dmem_be", 32'(dmem.dmem_be), 32'(exp_be));
                    cmp("dmem_wdata", dmem.dmem_wdata, exp_wdata);
                end
            end
            if (stall_m) stall_cnt++;
            if (dmem.dmem_req) begin
                req_cnt++;
                snap_wdata = dmem.dmem_wdata;
                snap_be    = dmem.dmem_be;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        memread_m   = 1'b0;
        memwrite_m  = 1'b0;
        funct3_m    = 3'd0;
        aluresult_m = 32'd0;
        writedata_m = 32'd0;
    endtask

    // One M-stage access; ack_at = n acks in the n-th request cycle, 0 never acks.
    task automatic do_access(input logic rdf, input logic wrf, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdata);
        bit done;
        memread_m = rdf; memwrite_m = wrf; funct3_m = f3; aluresult_m = a; writedata_m = wd;
        stall_cnt = 0;
        req_cnt   = 0;
        exp_err   = 1'b0;
        if (!model_legal(wrf, f3, a)) begin
            exp_fault = 1'b1; exp_stall = 1'b0; exp_req = 1'b0;
            step();
            clear_inputs();
            exp_fault = 1'b0;
            step();
            return;
        end
        exp_fault = 1'b0; exp_stall = 1'b1; exp_req = 1'b0;
        step();
        exp_req  = 1'b1;
        exp_we   = wrf;
        exp_addr = a & 32'hFFFFFFFC;
        model_store(f3, a, wd, exp_wdata, exp_be);
        done = 0;
        for (int i = 1; i <= MAXW && !done; i++) begin
            dmem.dmem_ack   = (i == ack_at);
            dmem.dmem_rdata = (i == ack_at) ? rdata : 32'h5A5A5A5A;
            step();
            if (i == ack_at) begin
                done   = 1;
                exp_rd = wrf ? 32'd0 : model_load(f3, a, rdata);
            end else if (i == MAXW) begin
                exp_rd  = 32'd0;
                exp_err = 1'b1;
            end
        end
        dmem.dmem_ack = 1'b0;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        step();
        clear_inputs();
        exp_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cmp("rst_rd", rd, 32'd0);
        cmp("rst_req", 32'(dmem.dmem_req), 32'd0);
        cmp("rst_we", 32'(dmem.dmem_we), 32'd0);
        cmp("rst_addr", dmem.dmem_addr, 32'd0);
        cmp("rst_wdata", dmem.dmem_wdata, 32'd0);
        cmp("rst_be", 32'(dmem.dmem_be), 32'd0);
        cmp("rst_err", 32'(bus_err_m), 32'd0);
        cmp("rst_stall", 32'(stall_m), 32'd0);
        exp_stall = 0; exp_fault = 0; exp_req = 0; exp_we = 0; exp_err = 0;
        exp_rd = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
        chk_en = 1;
        step();

        do_access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        cmp("lw_stall_cycles", 32'(stall_cnt), 32'd4);
        cmp("lw_rd", rd, 32'hDEADBEEF);
        step();

        do_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000);
        cmp("lb_stall_cycles", 32'(stall_cnt), 32'd2);
        cmp("lb_rd", rd, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0000);
        cmp("lbu_rd", rd, 32'h00000080);
        step();

        do_access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 2, 32'h0);
        cmp("sh_wdata", snap_wdata, 32'hABCDABCD);
        cmp("sh_be", 32'(snap_be), 32'hC);
        cmp("sh_rd", rd, 32'd0);
        cmp("sh_req_cycles", 32'(req_cnt), 32'd2);

        do_access(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h11111111);
        cmp("mis_stall_cycles", 32'(stall_cnt), 32'd0);
        cmp("mis_req_cycles", 32'(req_cnt), 32'd0);

        do_access(1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80011234);
        cmp("lh_rd", rd, 32'hFFFF8001);
        do_access(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
        do_access(0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
        do_access(0, 1, 3'b000, 32'h101, 32'h12345678, 1, 32'h0);
        cmp("sb_wdata", snap_wdata, 32'h78787878);
        cmp("sb_be", 32'(snap_be), 32'h2);
        do_access(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 32'h0);
        do_access(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80011234);
        cmp("lhu_rd", rd, 32'h00008001);
        do_access(1, 1, 3'b000, 32'h10, 32'h000000A5, 1, 32'hFFFFFFFF);
        cmp("both_rd", rd, 32'd0);
        do_access(1, 0, 3'b010, 32'h108, 32'h0, 1, 32'h13572468);
        step();

        do_access(1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h0);
        cmp("to_req_cycles", 32'(req_cnt), 32'd4);
        cmp("to_rd", rd, 32'd0);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hFFFFFFFF;
        step();
        step();
        dmem.dmem_ack = 1'b0;
        cmp("late_ack_rd", rd, 32'd0);
        step();

        do_access(1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h2468ACE0);
        memread_m = 1; funct3_m = 3'b010; aluresult_m = 32'h300;
        exp_stall = 1; exp_req = 0;
        step();
        exp_req = 1; exp_we = 0; exp_addr = 32'h300;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        exp_req = 0; exp_stall = 0; exp_rd = 0; exp_err = 0;
        cmp("midrst_addr", dmem.dmem_addr, 32'd0);
        cmp("midrst_be", 32'(dmem.dmem_be), 32'd0);
        cmp("midrst_rd", rd, 32'd0);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h55555555;
        step();
        step();
        dmem.dmem_ack = 1'b0;
        step();
        do_access(1, 0, 3'b000, 32'h101, 32'h0, 2, 32'h00007F00);
        cmp("post_rst_rd", rd, 32'h0000007F);
        step();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
